sram_ctrl: RTL and testbench

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_ctrl.sv | 96 +++++++++
 tb/tb_sram_ctrl.sv | 102 ++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// sram_ctrl: 32-bit requester to 16-bit async SRAM bridge, two half-word phases per access; define SRAM_PERF_CNT_EN for access counters.
module sram_ctrl #(
  parameter int DATA_W      = 32,
  parameter int SRAM_DW     = 16,
  parameter int SRAM_AW     = 18,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [DATA_W-1:0]  write_data,
  output logic [DATA_W-1:0]  read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_we_n,
  output logic [31:0]        rd_count,
  output logic [31:0]        wr_count
);
  localparam int IW = SRAM_AW - 1;
  localparam logic [3:0] RELOAD = 4'(WAIT_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [IW-1:0] idx;
  logic [DATA_W-1:0] wdata;
  logic [31:0] offs;
  logic last, lo, hi, wr_ph, unused_offs;
  assign offs        = address - 32'(BASE_ADDR);
  assign unused_offs = ^{offs[31:IW+2], offs[1:0]};
  assign last        = cnt == 4'd0;
  assign lo          = state == RD_LO || state == WR_LO;
  assign hi          = state == RD_HI || state == WR_HI;
  assign wr_ph       = state == WR_LO || state == WR_HI;
  always_comb begin
    state_nx = state;
    cnt_nx   = last ? 4'd0 : cnt - 4'd1;
    case (state)
      IDLE: begin
        state_nx = wr_en ? WR_LO : rd_en ? RD_LO : IDLE;
        cnt_nx   = (wr_en || rd_en) ? RELOAD : 4'd0;
      end
      RD_LO: if (last) begin state_nx = RD_HI; cnt_nx = RELOAD; end
      WR_LO: if (last) begin state_nx = WR_HI; cnt_nx = RELOAD; end
      RD_HI, WR_HI: if (last) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  assign ready       = state == DONE || (state == IDLE && !rd_en && !wr_en);
  assign sram_addr   = lo ? {idx, 1'b0} : hi ? {idx, 1'b1} : '0;
  assign sram_dq_oe  = wr_ph;
  // final cycle of each write phase releases the strobe for data hold
  assign sram_we_n   = !(wr_ph && !last);
  assign sram_dq_out = state == WR_LO ? wdata[SRAM_DW-1:0] :
                       state == WR_HI ? wdata[DATA_W-1:SRAM_DW] : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      idx       <= '0;
      wdata     <= '0;
      read_data <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == IDLE) begin
        idx   <= offs[IW+1:2];
        wdata <= write_data;
      end
      if (state == RD_LO && last) read_data[SRAM_DW-1:0] <= sram_dq_in;
      if (state == RD_HI && last) read_data[DATA_W-1:SRAM_DW] <= sram_dq_in;
    end
  end
`ifdef SRAM_PERF_CNT_EN
  logic is_wr;
  always_ff @(posedge clk) begin
    if (rst) begin
      is_wr    <= 1'b0;
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (state == IDLE) is_wr <= wr_en;
      if (state == DONE && is_wr) wr_count <= wr_count + 32'd1;
      if (state == DONE && !is_wr) rd_count <= rd_count + 32'd1;
    end
  end
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: randomized bench for sram_ctrl against a word-level memory model.
module tb_sram_ctrl;
  localparam int W = 5;
  localparam int BASE = 1024;
  logic clk = 0, rst = 1, rd_en = 0, wr_en = 0;
  logic [31:0] address = 0, write_data = 0, read_data, rd_count, wr_count;
  logic ready, sram_dq_oe, sram_we_n;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic [15:0] mem [4096];
  logic [31:0] ref_mem [2048];
  logic [31:0] last_rd = 0;
  int checks = 0, errors = 0, nrd = 0, nwr = 0;
  sram_ctrl #(.DATA_W(32), .SRAM_DW(16), .SRAM_AW(18), .BASE_ADDR(BASE), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n), .rd_count(rd_count), .wr_count(wr_count));
  always #5 clk = ~clk;
  assign sram_dq_in = mem[sram_addr[11:0]];
  always @(posedge clk) if (!sram_we_n && sram_dq_oe) mem[sram_addr[11:0]] <= sram_dq_out;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic access(input bit rd, input bit wr, input int idx, input logic [31:0] wd);
    bit hi;
    rd_en = rd; wr_en = wr; address = BASE + idx * 4; write_data = wd;
    for (int c = 0; c <= 2 * W + 1; c++) begin
      @(negedge clk);
      hi = c > W;
      if (c == 0) chk("ready_req", ready, 0);
      else if (c <= 2 * W) begin
        chk("ready_busy", ready, 0);
        chk("addr", sram_addr, 2 * idx + (hi ? 1 : 0));
        chk("we_n", sram_we_n, wr ? (c == W || c == 2 * W) : 1'b1);
        chk("oe", sram_dq_oe, wr);
        chk("dq", sram_dq_out, wr ? (hi ? wd[31:16] : wd[15:0]) : 16'h0);
      end else begin
        chk("ready_done", ready, 1);
        if (wr) begin ref_mem[idx] = wd; nwr++; end
        else begin last_rd = ref_mem[idx]; nrd++; end
        chk("read_data", read_data, last_rd);
      end
      @(posedge clk); #1;
      if (c == 3) begin address = $urandom; write_data = $urandom; end
    end
    rd_en = 0; wr_en = 0;
  endtask
  initial begin
    int n;
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 2048; i++) ref_mem[i] = {mem[2 * i + 1], mem[2 * i]};
    repeat (2) @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rst_ready", ready, 1); chk("rst_we_n", sram_we_n, 1); chk("rst_oe", sram_dq_oe, 0);
    chk("rst_addr", sram_addr, 0); chk("rst_rdata", read_data, 0);
    chk("rst_rdcnt", rd_count, 0); chk("rst_wrcnt", wr_count, 0);
    @(posedge clk); #1;
    wr_en = 1; address = BASE + 2000 * 4; write_data = 32'h12345678;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1; wr_en = 0;
    @(posedge clk); #1;
    rst = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("abort_ready", ready, 1); chk("abort_we_n", sram_we_n, 1); chk("abort_oe", sram_dq_oe, 0);
      @(posedge clk); #1;
    end
    chk("abort_rdata", read_data, 0);
    access(1, 0, 7, 0);
    access(0, 1, 1, 32'hDEADBEEF);
    access(1, 0, 1, 0);
    chk("beef_read", read_data, 32'hDEADBEEF);
    access(0, 1, 2, 32'hCAFEF00D);
    access(1, 0, 2, 0);
    chk("b2b_read", read_data, 32'hCAFEF00D);
    access(1, 1, 0, 32'hA5A55A5A);
    for (int t = 0; t < 40; t++) begin
      n = $urandom_range(0, 3);
      access(n != 0, n != 1, $urandom_range(0, 1023), $urandom);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk); chk("idle_ready", ready, 1);
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
`ifdef SRAM_PERF_CNT_EN
    chk("rd_count", rd_count, nrd);
    chk("wr_count", wr_count, nwr);
`else
    chk("rd_count", rd_count, 0);
    chk("wr_count", wr_count, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
